display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed controller for the four-digit seven-segment display. It owns one shared combinational hex-to-segment decoder and drives it one digit at a time. It scans the four anodes with an inter-digit blanking gap, which prevents ghosting. New values are loaded through a ready/load handshake and take effect only at a frame boundary, so a frame never shows a mix of old and new digits. The block sits between the value-producing logic and the board pins; the shared decoder hangs off `nibble` and `seg_in`.

## Interface
Parameters:
- `TICKS_PER_DIGIT`, default 100000: cycles each digit slot lasts. At 100 MHz this gives a 250 Hz frame.
- `BLANK_TICKS`, default 1000: cycles at the start of each slot with all anodes off. Constraint: 1 ≤ BLANK_TICKS < TICKS_PER_DIGIT.

Ports:
- `clk`, in, 1: single clock. Everything is on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `enable`, in, 1: 1 = scan; 0 = display dark and scan held at its start point.
- `value`, in, 16: four hex digits. `[3:0]` is digit 0 (rightmost, `an[0]`).
- `dp_mask`, in, 4: decimal-point request per digit, 1 = lit. Captured together with `value`.
- `load`, in, 1: single-cycle request to capture `value`/`dp_mask`. Honoured only when `ready`=1.
- `ready`, out, 1: 1 = no pending update, so `load` is accepted.
- `lz_blank`, in, 1: 1 = suppress leading zeros. Sampled live.
- `nibble`, out, 4: digit code presented to the shared decoder.
- `seg_in`, in, 7: decoder result for `nibble`, active-low.
- `seg`, out, 7: segment pins, active-low. 7'b1111111 = dark.
- `dp`, out, 1: decimal-point pin, active-low.
- `an`, out, 4: anode selects, active-low, at most one bit low.

## Operation
- Registers:
  - `shown[15:0]` and `shown_dp[3:0]`: the data currently displayed.
  - `pend[15:0]`, `pend_dp[3:0]`, `pend_v`: the pending update. `ready` = ~`pend_v`.
  - `digit[1:0]`, `cnt`: scan position; `cnt` counts 0..TICKS_PER_DIGIT-1.
- States:
  - IDLE (enable=0).
  - BLANK (`cnt` < BLANK_TICKS).
  - SHOW (`cnt` ≥ BLANK_TICKS).
- Transitions:
  - IDLE → BLANK of digit 0 with `cnt`=0 on the first edge where `enable`=1.
  - BLANK → SHOW when `cnt` reaches BLANK_TICKS.
  - SHOW → BLANK of `digit`+1 (mod 4) when `cnt`=TICKS_PER_DIGIT-1.
  - Any state → IDLE on an edge where `enable`=0.
- `nibble` = `shown[4*digit+3:4*digit]`. It is updated on the edge that enters BLANK, so it is stable for the whole slot.
- Entering SHOW: `seg` ← `seg_in`, `dp` ← ~`shown_dp[digit]`, `an` ← ~(1<<`digit`).
- Entering BLANK or IDLE: `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- During SHOW, `seg` keeps re-registering `seg_in` every cycle.
- Leading-zero blanking: with `lz_blank`=1, digit k ∈ {3,2,1} is suppressed when `shown` nibbles k..3 are all 0. A suppressed digit's SHOW keeps `an`=1111 and `seg`=7'h7F. Digit 0 is never suppressed.
- Handshake:
  - `load`=1 with `ready`=1: `pend` ← `value`, `pend_dp` ← `dp_mask`, `pend_v` ← 1.
  - `load` while `ready`=0 is ignored.
- Frame boundary is the edge leaving SHOW of digit 3. On that edge, if `pend_v`=1: `shown` ← `pend`, `shown_dp` ← `pend_dp`, `pend_v` ← 0. `nibble` takes the new `pend[3:0]` on the same edge.
- In IDLE, a pending update transfers on the next edge.

## Timing
- Reset values: `an`=4'b1111, `seg`=7'h7F, `dp`=1, `nibble`=0, `ready`=1, `shown`=`pend`=0, `digit`=0, `cnt`=0, state IDLE.
- Frame length is exactly 4×TICKS_PER_DIGIT cycles. Each digit is lit for TICKS_PER_DIGIT−BLANK_TICKS cycles.
- `ready` falls on the edge after an accepted `load`.
- `ready` rises on the boundary edge, or on the next IDLE edge.
- Maximum load-to-display latency is one frame plus BLANK_TICKS+1 cycles.
- `load` on the boundary edge with `ready`=1: the current `pend_v`=0, so nothing transfers. The new data is captured and shows from the following frame.
- `rst` mid-frame or with an update pending: all registers return to reset values on that edge and the pending data is discarded.
- `enable` falling mid-SHOW: the display is dark on the next edge. Scanning restarts at digit 0 BLANK after `enable` rises.
- `seg_in` is sampled only in SHOW cycles. The decoder's combinational delay must fit in one cycle from `nibble`.

## Test plan
All scenarios use TICKS_PER_DIGIT=8 and BLANK_TICKS=2.
- Reset, then enable=1, load `value`=16'h1234 with `dp_mask`=0:
  - `ready`=0 from the next cycle.
  - After the boundary, digit 0 shows `an`=1110 and `seg`=decode(4) for 6 cycles. Then 2 dark cycles, then `an`=1101 showing 3, and so on.
  - Frame period is 32 cycles.
- Load 16'hABCD, then assert `load` again with 16'h5555 while `ready`=0: the second load is ignored and 16'hABCD is displayed.
- `lz_blank`=1 with `value`=16'h0070:
  - Digits 3 and 2 keep `an`=1111 during their SHOW.
  - Digit 1 shows 7 and digit 0 shows 0.
  - With `value`=0, only digit 0 lights, showing 0.
- `dp_mask`=4'b0100: `dp`=0 only while `an`=1011.
- Assert `load` on the boundary edge: the old digits are kept for that frame and the new ones appear one frame later.
- `rst` during SHOW with an update pending: the next cycle shows reset values and `ready`=1. Drop `enable` mid-SHOW: the next cycle has `an`=1111.

Source files
------------

// File: rtl/display_scanner.sv
// Four-digit seven-segment scanner: one shared hex decoder, per-slot blanking gap,
// and value updates that only take effect at a frame boundary.
module display_scanner #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        load,
    output logic        ready,
    input  logic        lz_blank,
    output logic [3:0]  nibble,
    input  logic [6:0]  seg_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    // state | meaning
    // IDLE  | scan disabled, display dark, position parked at digit 0
    // BLANK | first BLANK_TICKS cycles of a slot, all anodes off
    // SHOW  | remainder of the slot, current digit lit (unless suppressed)

    localparam int CW = $clog2(TICKS_PER_DIGIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t          state;
    logic [15:0]     shown;
    logic [15:0]     pend;
    logic [3:0]      shown_dp;
    logic [3:0]      pend_dp;
    logic            pend_v;
    logic [1:0]      digit;
    logic [CW-1:0]   cnt;

    logic            lead_zero;
    logic            suppress;
    logic            at_boundary;
    logic            take_pend;
    logic [1:0]      next_digit;
    logic [15:0]     next_shown;
    logic [3:0]      lit_an;
    logic [6:0]      lit_seg;
    logic            lit_dp;

    always_comb begin
        lead_zero = 1'b0;
        case (digit)
            2'd3:    lead_zero = (shown[15:12] == 4'h0);
            2'd2:    lead_zero = (shown[15:8] == 8'h00);
            2'd1:    lead_zero = (shown[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
        suppress    = lz_blank && lead_zero;
        at_boundary = (state == SHOW) && (cnt == CNT_LAST) && (digit == 2'd3);
        // A pending update lands either at the frame boundary or on any IDLE edge.
        take_pend   = pend_v && ((state == IDLE) || (enable && at_boundary));
        next_shown  = take_pend ? pend : shown;
        next_digit  = digit + 2'd1;
        lit_an      = suppress ? 4'b1111 : ~(4'b0001 << digit);
        lit_seg     = suppress ? 7'h7F : seg_in;
        lit_dp      = suppress | ~shown_dp[digit];
    end

    assign ready = ~pend_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shown    <= '0;
            shown_dp <= '0;
            pend     <= '0;
            pend_dp  <= '0;
            pend_v   <= 1'b0;
            digit    <= '0;
            cnt      <= '0;
            nibble   <= '0;
            an       <= 4'b1111;
            seg      <= 7'h7F;
            dp       <= 1'b1;
        end else begin
            if (load && !pend_v) begin
                pend    <= value;
                pend_dp <= dp_mask;
                pend_v  <= 1'b1;
            end
            if (take_pend) begin
                shown    <= pend;
                shown_dp <= pend_dp;
                pend_v   <= 1'b0;
            end

            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
                digit <= '0;
                an    <= 4'b1111;
                seg   <= 7'h7F;
                dp    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= BLANK;
                        cnt    <= '0;
                        digit  <= '0;
                        nibble <= next_shown[3:0];
                        an     <= 4'b1111;
                        seg    <= 7'h7F;
                        dp     <= 1'b1;
                    end
                    BLANK: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == BLANK_LAST) begin
                            state <= SHOW;
                            an    <= lit_an;
                            seg   <= lit_seg;
                            dp    <= lit_dp;
                        end
                    end
                    SHOW: begin
                        if (cnt == CNT_LAST) begin
                            state  <= BLANK;
                            cnt    <= '0;
                            digit  <= next_digit;
                            nibble <= next_shown[{next_digit, 2'b00} +: 4];
                            an     <= 4'b1111;
                            seg    <= 7'h7F;
                            dp     <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                            an  <= lit_an;
                            seg <= lit_seg;
                            dp  <= lit_dp;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a frame-time model predicts every cycle's pins,
// a monitor compares them against the DUT after each edge.
module tb_display_scanner;

    localparam int T = 8;
    localparam int B = 2;
    localparam int F = 4 * T;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        load;
    logic        ready;
    logic        lz_blank;
    logic [3:0]  nibble;
    logic [6:0]  seg_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    display_scanner #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .dp_mask(dp_mask),
        .load(load), .ready(ready), .lz_blank(lz_blank), .nibble(nibble),
        .seg_in(seg_in), .seg(seg), .dp(dp), .an(an)
    );

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'b1000000;  4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;  4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;  4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;  4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;  4'h9: dec = 7'b0010000;
            4'hA: dec = 7'b0001000;  4'hB: dec = 7'b0000011;
            4'hC: dec = 7'b1000110;  4'hD: dec = 7'b0100001;
            4'hE: dec = 7'b0000110;  default: dec = 7'b0001110;
        endcase
    endfunction

    assign seg_in = dec(nibble);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] nib;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: scan position is a single frame-time index m_t (-1 = idle).
    bit          m_on = 1'b0;
    int          m_t = -1;
    logic [15:0] m_shown = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_shown_dp = '0;
    logic [3:0]  m_pend_dp = '0;
    logic [3:0]  m_nib = '0;
    bit          m_pv = 1'b0;

    always @(posedge clk) begin : model
        exp_t e;
        int   d, off;
        bit   xfer, acc, sup;
        if (rst) begin
            m_on = 1'b1; m_t = -1; m_pv = 1'b0; m_nib = '0;
            m_shown = '0; m_pend = '0; m_shown_dp = '0; m_pend_dp = '0;
        end else if (m_on) begin
            xfer = m_pv && (m_t < 0 || (enable && m_t == F - 1));
            acc  = load && !m_pv;
            if (acc) begin
                m_pend = value; m_pend_dp = dp_mask; m_pv = 1'b1;
            end
            if (xfer) begin
                m_shown = m_pend; m_shown_dp = m_pend_dp; m_pv = 1'b0;
            end
            m_t = !enable ? -1 : (m_t < 0 ? 0 : (m_t + 1) % F);
        end
        if (m_on) begin
            e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1;
            if (m_t >= 0) begin
                d   = m_t / T;
                off = m_t % T;
                if (off == 0) m_nib = m_shown[4*d +: 4];
                sup = lz_blank && d > 0 && (m_shown >> (4 * d)) == 16'h0;
                if (off >= B && !sup) begin
                    e.an  = ~(4'b0001 << d);
                    e.seg = dec(m_shown[4*d +: 4]);
                    e.dp  = ~m_shown_dp[d];
                end
            end
            e.nib = m_nib;
            e.rdy = !m_pv;
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("an", 16'(an), 16'(e.an));
            chk("seg", 16'(seg), 16'(e.seg));
            chk("dp", 16'(dp), 16'(e.dp));
            chk("nibble", 16'(nibble), 16'(e.nib));
            chk("ready", 16'(ready), 16'(e.rdy));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        load = 1'b1; value = v; dp_mask = m;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_free();
        for (int i = 0; i < 200 && m_pv; i++) @(negedge clk);
        checks++;
        if (m_pv) begin
            fails++;
            $display("FAIL wait_free: pending update never cleared");
        end
    endtask

    // Wait until the slot offset lies in [lo,hi] and, if dig >= 0, the digit matches.
    task automatic wait_slot(input int dig, input int lo, input int hi);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = m_t >= 0 && (m_t % T) >= lo && (m_t % T) <= hi && (dig < 0 || m_t / T == dig);
            if (!hit) @(negedge clk);
        end
        checks++;
        if (!hit) begin
            fails++;
            $display("FAIL wait_slot: position digit %0d offset %0d..%0d not reached", dig, lo, hi);
        end
    endtask

    function automatic logic [15:0] rnd_value();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 4))
            0: v &= 16'h000F;
            1: v &= 16'h00FF;
            2: v &= 16'h0FFF;
            3: v = 16'h0000;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_mask = '0; lz_blank = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        enable = 1'b1;
        do_load(16'h1234, 4'b0000);
        cyc(80);

        do_load(16'hABCD, 4'b0000);
        do_load(16'h5555, 4'b1111);
        cyc(70);

        lz_blank = 1'b1;
        do_load(16'h0070, 4'b0000);
        cyc(70);
        do_load(16'h0000, 4'b0000);
        cyc(70);
        lz_blank = 1'b0;

        do_load(16'h1111, 4'b0100);
        cyc(70);

        wait_free();
        wait_slot(3, T - 1, T - 1);
        do_load(16'h2468, 4'b0001);
        cyc(80);

        wait_free();
        do_load(16'h9876, 4'b1000);
        wait_slot(-1, B + 1, T - 2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(40);

        wait_slot(-1, B + 2, T - 2);
        enable = 1'b0;
        cyc(2);
        do_load(16'hC0DE, 4'b0010);
        cyc(3);
        enable = 1'b1;
        cyc(50);

        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (!enable) enable = ($urandom_range(0, 3) == 0);
            else enable = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 199) == 0) lz_blank = ~lz_blank;
            load    = ($urandom_range(0, 7) == 0);
            value   = rnd_value();
            dp_mask = 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; load = 1'b0; enable = 1'b1;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
